// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a 4-bit universal shift register.
// Each accepted command becomes one LOAD cycle, then cmd_count shift cycles,
// then a one-cycle done pulse. All outputs are decoded from registered state.
// The single exception is reg_q[0] -> rightInp during a rotate.
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] reg_q,
    output logic [WIDTH-1:0] INP,
    output logic [1:0]       select,
    output logic             leftInp,
    output logic             rightInp,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;

    // Only bit 0 of the fed-back register value is needed (rotate wrap-around).
    logic unused_reg_q;
    assign unused_reg_q = ^reg_q[WIDTH-1:1];

    // State and captured command fields; reset returns to IDLE immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    // Next state: fields are sampled only on the IDLE handshake, so later
    // changes on the command bus cannot disturb a running command.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    cnt_d   = cmd_count;
                    fill_d  = cmd_fill;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // A zero count degenerates any shift op into a plain load.
                if (op_q == OP_LOAD || cnt_q == '0) state_d = S_DONE;
                else                                 state_d = S_SHIFT;
            end
            S_SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; serial inputs not in use are held at 0.
    always_comb begin
        select   = SEL_HOLD;
        leftInp  = 1'b0;
        rightInp = 1'b0;
        INP      = data_q;
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        unique case (state_q)
            S_LOAD: select = SEL_LOAD;
            S_SHIFT: begin
                if (op_q == OP_SHL) begin
                    select  = SEL_SHL;
                    leftInp = fill_q;
                end else begin
                    select   = SEL_SHR;
                    rightInp = (op_q == OP_SHR) ? fill_q : reg_q[0];
                end
            end
            default: select = SEL_HOLD;
        endcase
    end

endmodule
